hazard_stall_ctrl: RTL and testbench

Stall controller for the five-stage MIPS pipeline. It decides each cycle whether the F/D and D/E pipeline registers advance or hold, using Tuse/Tnew register-dependency checks. It also owns the busy countdown for the shared multiply/divide unit (HI/LO), so that an instruction in D that needs the unit holds until the unit is free. The E/M and M/W registers never stall and are not controlled here.

---
 rtl/hazard_stall_ctrl_pkg.sv | 9 +
 rtl/hazard_stall_ctrl_md_busy_counter.sv | 35 +++
 rtl/hazard_stall_ctrl.sv | 55 +++++
 tb/tb_hazard_stall_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_stall_ctrl_pkg: shared pipeline constants for the stall controller
package hazard_stall_ctrl_pkg;
   localparam int REG_W        = 5;
   localparam int T_W          = 2;
   localparam logic [T_W-1:0] TUSE_NONE = 2'd3;
   localparam int MULT_CYC_DEF = 5;
   localparam int DIV_CYC_DEF  = 10;
   localparam int MD_CNT_W     = 4;
endpackage

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
// md_busy_counter: busy countdown and overlap flag for the shared HI/LO unit
module md_busy_counter
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int MULT_CYC = MULT_CYC_DEF,
   parameter int DIV_CYC  = DIV_CYC_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic E_md_start,
   input  logic E_md_div,
   output logic md_busy,
   output logic md_overlap_err
);
   logic [MD_CNT_W-1:0] r_cnt;
   logic                r_err;
   logic                w_idle;
   logic [MD_CNT_W-1:0] w_cnt_nxt;
   assign w_idle = (r_cnt == '0);
   // a start while busy is ignored for loading; the countdown keeps going
   always_comb
      w_cnt_nxt = (E_md_start && w_idle) ? (E_md_div ? MD_CNT_W'(DIV_CYC) : MD_CNT_W'(MULT_CYC))
                : !w_idle ? r_cnt - MD_CNT_W'(1) : r_cnt;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         r_cnt <= w_cnt_nxt;
         r_err <= r_err | (E_md_start & !w_idle);
      end
   end
   assign md_busy        = E_md_start | !w_idle;
   assign md_overlap_err = r_err;
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: Tuse/Tnew dependency and mul/div-busy stall control for F/D and D/E
module hazard_stall_ctrl
   import hazard_stall_ctrl_pkg::*;
#(
   parameter int MULT_CYC = MULT_CYC_DEF,
   parameter int DIV_CYC  = DIV_CYC_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] D_rs,
   input  logic [REG_W-1:0] D_rt,
   input  logic [T_W-1:0]   D_tuse_rs,
   input  logic [T_W-1:0]   D_tuse_rt,
   input  logic             D_is_md,
   input  logic [REG_W-1:0] E_wa,
   input  logic [REG_W-1:0] M_wa,
   input  logic [T_W-1:0]   E_tnew,
   input  logic [T_W-1:0]   M_tnew,
   input  logic             E_md_start,
   input  logic             E_md_div,
   output logic             stall,
   output logic             PC_en,
   output logic             FD_en,
   output logic             DE_clr,
   output logic             md_busy,
   output logic             md_overlap_err,
   output logic [31:0]      stall_cycles
);
   logic        w_stall_rs, w_stall_rt, w_stall_md, w_md_busy;
   logic [31:0] r_stall_cycles;
   md_busy_counter #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) u_md (
      .clk(clk),
      .reset(reset),
      .E_md_start(E_md_start),
      .E_md_div(E_md_div),
      .md_busy(w_md_busy),
      .md_overlap_err(md_overlap_err)
   );
   // $0 is hardwired, so a match against it is never a real dependency
   always_comb begin
      w_stall_rs = (D_rs != '0) & ((D_rs == E_wa & E_tnew > D_tuse_rs) | (D_rs == M_wa & M_tnew > D_tuse_rs));
      w_stall_rt = (D_rt != '0) & ((D_rt == E_wa & E_tnew > D_tuse_rt) | (D_rt == M_wa & M_tnew > D_tuse_rt));
      w_stall_md = D_is_md & w_md_busy;
   end
   always_ff @(posedge clk) begin
      if (reset) r_stall_cycles <= '0;
      else if (stall) r_stall_cycles <= r_stall_cycles + 32'd1;
   end
   assign stall        = w_stall_rs | w_stall_rt | w_stall_md;
   assign PC_en        = !stall;
   assign FD_en        = !stall;
   assign DE_clr       = stall;
   assign md_busy      = w_md_busy;
   assign stall_cycles = r_stall_cycles;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed and randomized checks against a cycle-indexed reference model
module tb_hazard_stall_ctrl;
   import hazard_stall_ctrl_pkg::*;
   localparam int MC = 5, DC = 10;
   logic clk = 0, reset = 1;
   logic [4:0] D_rs = 0, D_rt = 0, E_wa = 0, M_wa = 0;
   logic [1:0] D_tuse_rs = TUSE_NONE, D_tuse_rt = TUSE_NONE, E_tnew = 0, M_tnew = 0;
   logic D_is_md = 0, E_md_start = 0, E_md_div = 0;
   logic stall, PC_en, FD_en, DE_clr, md_busy, md_overlap_err;
   logic [31:0] stall_cycles;
   int n_checks = 0, n_errors = 0;
   longint cyc = 0, free_at = 0;
   logic m_err = 0;
   logic [31:0] m_cnt = 0;

   hazard_stall_ctrl #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
      .clk(clk), .reset(reset), .D_rs(D_rs), .D_rt(D_rt), .D_tuse_rs(D_tuse_rs), .D_tuse_rt(D_tuse_rt),
      .D_is_md(D_is_md), .E_wa(E_wa), .M_wa(M_wa), .E_tnew(E_tnew), .M_tnew(M_tnew),
      .E_md_start(E_md_start), .E_md_div(E_md_div), .stall(stall), .PC_en(PC_en), .FD_en(FD_en),
      .DE_clr(DE_clr), .md_busy(md_busy), .md_overlap_err(md_overlap_err), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // a source is late if its producer delivers after the cycle D needs it
   function automatic logic late(input logic [4:0] r, input logic [1:0] tuse);
      int need;
      need = tuse;
      if (r == 0) return 0;
      return (r == E_wa && int'(E_tnew) > need) || (r == M_wa && int'(M_tnew) > need);
   endfunction

   function automatic logic m_busy();
      return E_md_start || cyc < free_at;
   endfunction

   function automatic logic m_stall();
      return late(D_rs, D_tuse_rs) || late(D_rt, D_tuse_rt) || (D_is_md && m_busy());
   endfunction

   task automatic mid();
      #4;
      check("stall", stall, m_stall());
      check("pc_en", PC_en, !m_stall());
      check("fd_en", FD_en, !m_stall());
      check("de_clr", DE_clr, m_stall());
      check("md_busy", md_busy, m_busy());
      check("md_err", md_overlap_err, m_err);
      check("stall_cycles", stall_cycles, m_cnt);
   endtask

   task automatic edge_step();
      if (reset) begin
         free_at = cyc + 1;
         m_err = 0;
         m_cnt = 0;
      end else begin
         if (E_md_start) begin
            if (cyc >= free_at) free_at = cyc + 1 + (E_md_div ? DC : MC);
            else m_err = 1;
         end
         if (m_stall()) m_cnt++;
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic clear_inputs();
      D_rs = 0; D_rt = 0; E_wa = 0; M_wa = 0; E_tnew = 0; M_tnew = 0;
      D_tuse_rs = TUSE_NONE; D_tuse_rt = TUSE_NONE; D_is_md = 0; E_md_start = 0; E_md_div = 0;
   endtask

   task automatic do_reset();
      reset = 1; mid(); edge_step(); reset = 0;
   endtask

   initial begin
      int n;
      @(posedge clk); #1;
      do_reset();
      D_tuse_rs = 0; D_tuse_rt = 0;
      mid();
      check("rst_stall", stall, 0); check("rst_pc_en", PC_en, 1); check("rst_busy", md_busy, 0);
      check("rst_cnt", stall_cycles, 0);
      edge_step();
      D_rs = 8; D_tuse_rs = 0; E_wa = 8; E_tnew = 2;
      mid(); check("lu_stall", stall, 1); check("lu_pc_en", PC_en, 0); check("lu_de_clr", DE_clr, 1);
      edge_step();
      E_tnew = 0;
      mid(); check("lu_clear", stall, 0); edge_step();
      D_rs = 0; E_wa = 0; E_tnew = 2;
      mid(); check("zero_reg", stall, 0); edge_step();
      clear_inputs();
      D_rt = 5; D_tuse_rt = 0; M_wa = 5; M_tnew = 1;
      mid(); check("m_dep", stall, 1); edge_step();
      D_tuse_rt = 1;
      mid(); check("m_dep_ok", stall, 0); edge_step();
      clear_inputs();
      do_reset();
      D_is_md = 1; E_md_start = 1; n = 0;
      for (int i = 0; i < 10; i++) begin
         mid(); if (stall) n++; edge_step(); E_md_start = 0;
      end
      check("mult_stall_len", n, 6);
      check("mult_stall_cnt", stall_cycles, 6);
      do_reset();
      E_md_start = 1; E_md_div = 1;
      for (int i = 0; i < 3; i++) begin
         mid(); edge_step(); E_md_start = 0;
      end
      reset = 1; mid(); check("div_busy_4th", md_busy, 1); edge_step(); reset = 0;
      mid(); check("div_rst_busy", md_busy, 0); check("div_rst_cnt", stall_cycles, 0); edge_step();
      clear_inputs();
      E_md_start = 1;
      for (int k = 0; k <= 7; k++) begin
         mid();
         if (k == 5) check("ovl_busy_t5", md_busy, 1);
         if (k == 6) check("ovl_busy_t6", md_busy, 0);
         if (k == 7) check("ovl_err", md_overlap_err, 1);
         edge_step();
         E_md_start = (k == 1);
      end
      do_reset();
      mid(); check("ovl_err_clr", md_overlap_err, 0); edge_step();
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 99) == 0);
         D_rs = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
         D_rt = 5'($urandom_range(0, 3));
         E_wa = 5'($urandom_range(0, 3)); M_wa = 5'($urandom_range(0, 3));
         D_tuse_rs = 2'($urandom); D_tuse_rt = 2'($urandom);
         E_tnew = 2'($urandom); M_tnew = 2'($urandom);
         D_is_md = ($urandom_range(0, 2) == 0);
         E_md_start = ($urandom_range(0, 11) == 0);
         E_md_div = 1'($urandom);
         mid(); edge_step();
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
